// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr
// Sticky-request arbiter with a registered grant and a ready/valid handshake.
// mode = 0 selects the highest-index candidate; mode = 1 rotates downward
// starting just below the most recent grant. Requests that are not granted
// stay in the pending register until they win.

module priority_arbiter_rr #(
  parameter int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  pending
);

  // Returns {found, index} of the winning candidate. The loop visits
  // positions from lowest to highest priority, so the last hit wins.
  function automatic logic [IW:0] pick_winner(
    input logic [N-1:0]  cand,
    input logic          rr,
    input logic [IW-1:0] last
  );
    logic [IW:0] res;
    int          pos;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr) begin
        // k = 0 is (last - 1) mod N, the first position of the downward search
        pos = (int'(last) + 2 * N - 1 - k) % N;
      end else begin
        // k = 0 is N-1, the highest index
        pos = N - 1 - k;
      end
      if (cand[pos]) begin
        res = {1'b1, pos[IW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic          out_valid_r;
  logic [IW-1:0] out_idx_r;
  logic [N-1:0]  pending_r;
  logic [IW-1:0] last_r;

  logic [N-1:0]  cand_s;
  logic          load_s;
  logic [IW:0]   pick_s;
  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic [N-1:0]  win_onehot_s;

  // Candidate set, load enable and winner selection for the coming edge
  always_comb begin
    cand_s       = pending_r | req;
    load_s       = (~out_valid_r) | out_ready;
    pick_s       = pick_winner(cand_s, mode, last_r);
    win_found_s  = pick_s[IW];
    win_idx_s    = pick_s[IW-1:0];
    win_onehot_s = '0;
    if (win_found_s) begin
      win_onehot_s[win_idx_s] = 1'b1;
    end else begin
      win_onehot_s = '0;
    end
  end

  // Grant, pending and last-grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      pending_r   <= '0;
      last_r      <= '0;
    end else if (load_s) begin
      if (win_found_s) begin
        out_valid_r <= 1'b1;
        out_idx_r   <= win_idx_s;
        pending_r   <= cand_s & ~win_onehot_s;
        last_r      <= win_idx_s;
      end else begin
        // nothing to grant: drop valid, keep the last index on the bus
        out_valid_r <= 1'b0;
        out_idx_r   <= out_idx_r;
        pending_r   <= '0;
        last_r      <= last_r;
      end
    end else begin
      // grant held under backpressure; new requests (including a
      // re-request of the held channel) accumulate in pending
      out_valid_r <= out_valid_r;
      out_idx_r   <= out_idx_r;
      pending_r   <= cand_s;
      last_r      <= last_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign pending   = pending_r;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr with N = 4: a vector table for the
// steady-state behaviour plus hand-written reset sequences.

module tb_priority_arbiter_rr;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          mode;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic [N-1:0]  pending;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [N-1:0]  req;
    logic          mode;
    logic          rdy;
    logic          exp_valid;
    logic [IW-1:0] exp_idx;
    logic [N-1:0]  exp_pending;
  } vec_t;

  vec_t vecs[$];

  priority_arbiter_rr #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic v, input logic [IW-1:0] i,
                           input logic [N-1:0] p);
    check({name, ".valid"},   int'(out_valid), int'(v));
    check({name, ".idx"},     int'(out_idx),   int'(i));
    check({name, ".pending"}, int'(pending),   int'(p));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [N-1:0] r, input logic m, input logic rd,
                     input logic v, input logic [IW-1:0] i, input logic [N-1:0] p);
    vec_t e;
    e.req = r; e.mode = m; e.rdy = rd;
    e.exp_valid = v; e.exp_idx = i; e.exp_pending = p;
    vecs.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // round-robin fairness right after reset (last = 0 -> starts at 3)
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0111);
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011);
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1101);
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1110);
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b0111);
    add(4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011);
    // same stimulus in fixed priority: 3 every cycle, then drain
    add(4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0111);
    add(4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0111);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0011);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0001);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
    // fixed priority single pulse 1101 -> 3, 2, 0, idle
    add(4'b1101, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0101);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0001);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000);
    // backpressure: grant 0 held, 3 queued, then released
    add(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
    add(4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000);
    // re-request of held channel 2 under backpressure
    add(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000);
    add(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000);
    // re-request in the same cycle as the handshake
    add(4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000);
    add(4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000);
    // repeated req on a pending channel merges into one grant
    add(4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000);
    add(4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010);
    add(4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000);
    // round-robin from last = 1 picks 0; mode change does not disturb the hold
    add(4'b0101, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0100);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0100);
    add(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000);

    // reset held with all requests asserted
    rst_n = 1'b0; req = 4'b1111; mode = 1'b0; out_ready = 1'b1;
    #2;
    check_all("reset_async", 1'b0, 2'd0, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick;
      check_all("reset_hold", 1'b0, 2'd0, 4'b0000);
    end
    req = 4'b0000;
    rst_n = 1'b1;
    tick;
    check_all("reset_release", 1'b0, 2'd0, 4'b0000);

    // table
    for (int v = 0; v < vecs.size(); v++) begin
      req = vecs[v].req; mode = vecs[v].mode; out_ready = vecs[v].rdy;
      tick;
      check_all($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_idx,
                vecs[v].exp_pending);
    end

    // async reset mid-grant with pending = 0011
    req = 4'b0100; mode = 1'b0; out_ready = 1'b0;
    tick;
    check_all("pre_rst_grant", 1'b1, 2'd2, 4'b0000);
    req = 4'b0011;
    tick;
    check_all("pre_rst_pend", 1'b1, 2'd2, 4'b0011);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst_async", 1'b0, 2'd0, 4'b0000);
    req = 4'b1111;
    tick;
    check_all("mid_rst_hold", 1'b0, 2'd0, 4'b0000);
    req = 4'b0000;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    check_all("post_rst_idle", 1'b0, 2'd0, 4'b0000);
    // last cleared to 0 -> first round-robin search starts at 3
    req = 4'b1001; mode = 1'b1;
    tick;
    check_all("post_rst_rr", 1'b1, 2'd3, 4'b0001);
    req = 4'b0000;
    tick;
    check_all("post_rst_rr2", 1'b1, 2'd0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
